// File: rtl/fb_pixel_fetch.sv
// Pixel fetch stage: raster position -> framebuffer read -> palette lookup -> RGB,
// with hsync/vsync/de delayed to stay aligned with the three-cycle pixel latency.
module fb_pixel_fetch #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480,
  parameter int SCALE    = 2,
  parameter int IDX_W    = 4,
  parameter int ADDR_W   = 18
) (
  input  logic              pixel_clk,
  input  logic              rst_pixel,
  input  logic [9:0]        sx,
  input  logic [9:0]        sy,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              de,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd_en,
  input  logic [IDX_W-1:0]  fb_data,
  input  logic              pal_we,
  input  logic [IDX_W-1:0]  pal_idx,
  input  logic [11:0]       pal_rgb,
  input  logic              swap_req,
  output logic              front_buf,
  output logic              swap_done,
  output logic [11:0]       rgb,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              de_o
);

  localparam int FB_W    = H_ACTIVE / SCALE;
  localparam int FB_H    = V_ACTIVE / SCALE;
  localparam int FB_SIZE = FB_W * FB_H;

  logic [11:0]       palette [2**IDX_W];
  logic              pending;
  logic [9:0]        row, col, row_q;
  logic [ADDR_W-1:0] base, base_q, addr_next;
  logic              swap_pt, do_swap, front_next;
  logic              de1, hs1, vs1, de2, hs2, vs2;

  assign row        = sy / 10'(SCALE);
  assign col        = sx / 10'(SCALE);
  assign swap_pt    = (sy == 10'(V_ACTIVE)) && (sx == 10'd0);
  assign do_swap    = swap_pt && (pending || swap_req);
  assign front_next = front_buf ^ do_swap;

  // Row base follows the raster one scaled row at a time; arbitrary jumps recompute it.
  always_comb begin
    base = base_q;
    if (row == row_q)
      base = base_q;
    else if (row == row_q + 10'd1)
      base = base_q + ADDR_W'(FB_W);
    else
      base = ADDR_W'(row) * ADDR_W'(FB_W);
  end

  assign addr_next = (front_next ? ADDR_W'(FB_SIZE) : '0) + base + ADDR_W'(col);

  always_ff @(posedge pixel_clk) begin
    if (rst_pixel) begin
      fb_addr   <= '0;
      fb_rd_en  <= 1'b0;
      rgb       <= 12'h000;
      de_o      <= 1'b0;
      hsync_o   <= 1'b1;
      vsync_o   <= 1'b1;
      front_buf <= 1'b0;
      swap_done <= 1'b0;
      pending   <= 1'b0;
      row_q     <= '0;
      base_q    <= '0;
      de1       <= 1'b0;
      hs1       <= 1'b1;
      vs1       <= 1'b1;
      de2       <= 1'b0;
      hs2       <= 1'b1;
      vs2       <= 1'b1;
      for (int i = 0; i < 2**IDX_W; i++) palette[i] <= 12'h000;
    end else begin
      front_buf <= front_next;
      swap_done <= do_swap;
      pending   <= do_swap ? 1'b0 : (pending | swap_req);
      row_q     <= row;
      base_q    <= base;
      fb_rd_en  <= de;
      if (de) fb_addr <= addr_next;
      de1 <= de;
      hs1 <= hsync;
      vs1 <= vsync;
      de2 <= de1;
      hs2 <= hs1;
      vs2 <= vs1;
      // RAM data for the stage-1 read arrives now; lookup sees the pre-write palette.
      rgb     <= de2 ? palette[fb_data] : 12'h000;
      de_o    <= de2;
      hsync_o <= hs2;
      vsync_o <= vs2;
      if (pal_we) palette[pal_idx] <= pal_rgb;
    end
  end

endmodule

// File: doc/fb_pixel_fetch.md
Name: fb_pixel_fetch

Overview:
- Stage directly downstream of the VGA timing generator, on the pixel clock.
- Takes the raster position (sx, sy) and the control signals (hsync, vsync, de). Converts the position into a read address for a double-buffered, SCALE-upscaled indexed framebuffer held in external synchronous RAM.
- Looks up each returned colour index in an internal 16-entry RGB444 palette.
- Emits RGB plus control signals delayed to match the pixel latency, ready for the panel pins.

Parameters:
- H_ACTIVE, 800, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- SCALE, 2, upscale factor; framebuffer is FB_W = H_ACTIVE/SCALE by FB_H = V_ACTIVE/SCALE (400x240).
- IDX_W, 4, colour index width; palette depth is 2**IDX_W.
- ADDR_W, 18, framebuffer address width; must hold 2*FB_W*FB_H-1.

Ports:
- pixel_clk  in  1  pixel clock; all logic on its rising edge.
- rst_pixel  in  1  synchronous, active-high reset.
- sx  in  10  raster x position.
- sy  in  10  raster y position.
- hsync  in  1  horizontal sync, negative polarity.
- vsync  in  1  vertical sync, negative polarity.
- de  in  1  data enable (active pixel).
- fb_addr  out  ADDR_W  framebuffer read address.
- fb_rd_en  out  1  read strobe for fb_addr.
- fb_data  in  IDX_W  RAM read data, valid exactly one cycle after fb_rd_en.
- pal_we  in  1  palette write enable.
- pal_idx  in  IDX_W  palette entry to write.
- pal_rgb  in  12  RGB444 write value {R,G,B}.
- swap_req  in  1  one-cycle pulse requesting a buffer swap.
- front_buf  out  1  buffer currently scanned out.
- swap_done  out  1  one-cycle pulse when a swap takes effect.
- rgb  out  12  output pixel {R[3:0],G[3:0],B[3:0]}.
- hsync_o  out  1  hsync delayed 3 cycles.
- vsync_o  out  1  vsync delayed 3 cycles.
- de_o  out  1  de delayed 3 cycles.

Behaviour:
- Reset (rst_pixel high at an edge):
  - Outputs: fb_addr=0, fb_rd_en=0, rgb=0, de_o=0, hsync_o=1, vsync_o=1, front_buf=0, swap_done=0.
  - All delay-line stages: de=0, syncs=1.
  - State: swap pending cleared, all palette entries 0.
  - Reset mid-frame discards in-flight pixels. The first valid output follows 3 cycles after reset deasserts.
- Pipeline (inputs sampled at edge N):
  - N+1: fb_addr and fb_rd_en registered.
  - N+2: fb_data sampled and looked up in the palette.
  - N+3: rgb, hsync_o, vsync_o and de_o valid.
  - Fixed latency of 3; all four outputs stay cycle-aligned.
- Address rule:
  - When de=1: fb_addr = front_buf*FB_W*FB_H + (sy/SCALE)*FB_W + (sx/SCALE), with integer division, and fb_rd_en=1.
  - Use sub-pixel/row-base counters, not multipliers. The result must equal the formula every active cycle.
  - When de=0: fb_rd_en=0 and fb_addr holds its previous value.
- front_buf used in the address is the value registered at the same edge, after any swap update.
- Pixel output: rgb = palette[fb_data] when the delayed de is 1, otherwise 12'h000.
- Palette:
  - A write with pal_we=1 at edge N updates palette[pal_idx] at N.
  - A lookup at the same edge returns the old value; lookups from N+1 onward see the new value.
  - Writes are allowed at any time.
- Double buffer:
  - swap_req=1 sets a pending flag. Repeated requests while pending have no extra effect.
  - Swap point: the cycle with sy==V_ACTIVE and sx==0 (first blanking line).
  - At the swap point, if pending or swap_req=1 in that cycle: front_buf toggles, pending clears, and swap_done=1 for exactly that cycle's registered output.
  - No request at the swap point: nothing changes. front_buf never changes outside the swap point.
- Input range: sx/sy beyond the active area only occur with de=0; no address is generated for them.

Test Plan:
- Reset: hold rst_pixel 2 cycles mid-line with de=1 -> fb_rd_en=0, rgb=0, de_o=0, hsync_o=vsync_o=1, front_buf=0; after release with de=1, de_o first returns 1 three cycles later.
- Address scaling: sy=0, sx=0,1,2,3 with de=1, front_buf=0 -> fb_addr 0,0,1,1 one cycle later, fb_rd_en=1; sy=3, sx=5 -> 402; sx=799, sy=479 -> 95999; with front_buf=1, sy=3, sx=5 -> 96402.
- Palette path: write palette[5]=12'hABC; hold fb_data=5 one cycle after fb_rd_en -> rgb=12'hABC at input+3; same-cycle write of palette[5]=12'h123 during lookup -> old value 12'hABC output, next pixel 12'h123.
- Sync alignment: hsync pulse at sx 823..894 -> hsync_o low exactly 3 cycles later for 72 cycles; de=0 -> rgb=0 and fb_rd_en=0 regardless of fb_data.
- Swap: swap_req pulse at sy=100 -> front_buf toggles 0->1 at sy=480, sx=0, swap_done high 1 cycle; a second swap_req at sy=200 in the same frame causes one toggle only; swap_req exactly at the swap point with none pending -> toggles that cycle.
- Reset mid-swap: swap pending, rst_pixel asserted at sy=300 -> front_buf=0, no swap_done at sy=480.
